// File: rtl/asic_iopoc_seq.sv
// Padring power-on-control sequencer: enables supply segments in order, releases
// poc once every segment is good, powers down in reverse and latches faults.
module asic_iopoc_seq #(
  parameter int N       = 4,
  parameter int CW      = 16,
  parameter int DELAY   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] pwr_good,
  output logic [N-1:0] seg_en,
  output logic [N-1:0] poc,
  output logic         ready,
  output logic         fault
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] DLY_M1 = CW'(DELAY - 1);
  localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, RAMP, CHECK, ON, DOWN, FAULT} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      seg_en <= '0;
      poc    <= '1;
      ready  <= 1'b0;
      fault  <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (en) begin
          state     <= RAMP;
          idx       <= '0;
          cnt       <= '0;
          seg_en[0] <= 1'b1;
        end
        RAMP: begin
          if (!en) begin
            state <= DOWN;
            cnt   <= '0;
            poc   <= '1;
            ready <= 1'b0;
          end else if (cnt == DLY_M1) begin
            state <= CHECK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CHECK: begin
          if (!en) begin
            state <= DOWN;
            cnt   <= '0;
            poc   <= '1;
            ready <= 1'b0;
          end else if (pwr_good[idx]) begin
            if (idx == LAST) begin
              state <= ON;
              poc   <= '0;
              ready <= 1'b1;
            end else begin
              idx                  <= idx + IW'(1);
              seg_en[idx + IW'(1)] <= 1'b1;
              cnt                  <= '0;
              state                <= RAMP;
            end
          end else if (cnt == TO_M1) begin
            state  <= FAULT;
            seg_en <= '0;
            poc    <= '1;
            ready  <= 1'b0;
            fault  <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ON: begin
          // brown-out is checked ahead of a requested power-down
          if (pwr_good != '1) begin
            state  <= FAULT;
            seg_en <= '0;
            poc    <= '1;
            ready  <= 1'b0;
            fault  <= 1'b1;
            cnt    <= '0;
          end else if (!en) begin
            state <= DOWN;
            cnt   <= '0;
            poc   <= '1;
            ready <= 1'b0;
          end
        end
        DOWN: begin
          // drop segment idx at the start of its window, step down at the end
          if (cnt == '0) seg_en[idx] <= 1'b0;
          if (cnt == DLY_M1) begin
            cnt <= '0;
            if (idx == '0) state <= IDLE;
            else           idx   <= idx - IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FAULT: if (!en) begin
          state <= IDLE;
          fault <= 1'b0;
          idx   <= '0;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_asic_iopoc_seq.sv
// Bench for asic_iopoc_seq: directed scenarios plus randomized traffic, all
// checked every cycle against a segment-count based reference model.
module tb_asic_iopoc_seq;
  localparam int N = 4, CW = 16, DELAY = 4, TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         reset, en;
  logic [N-1:0] pwr_good, seg_en, poc;
  logic         ready, fault;

  asic_iopoc_seq #(.N(N), .CW(CW), .DELAY(DELAY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .en(en), .pwr_good(pwr_good),
    .seg_en(seg_en), .poc(poc), .ready(ready), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference: phase name, number of enabled segments, segment under work, timer
  localparam int M_IDLE = 0, M_UP = 1, M_WAIT = 2, M_ON = 3, M_DOWN = 4, M_FLT = 5;
  int  m_mode, m_k, m_i, m_t;
  bit  m_safe, m_ready, m_fault;
  logic [N-1:0] pg_mask;
  bit  follow;

  function automatic logic [N-1:0] exp_seg();
    logic [N-1:0] v = '0;
    for (int i = 0; i < m_k; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_edge(input bit r, input bit e, input logic [N-1:0] pg);
    if (r) begin
      m_mode = M_IDLE; m_k = 0; m_i = 0; m_t = 0;
      m_safe = 1; m_ready = 0; m_fault = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (e) begin m_mode = M_UP; m_k = 1; m_i = 0; m_t = 0; end
      M_UP:
        if (!e) begin m_mode = M_DOWN; m_t = 0; end
        else if (m_t == DELAY - 1) begin m_mode = M_WAIT; m_t = 0; end
        else m_t++;
      M_WAIT:
        if (!e) begin m_mode = M_DOWN; m_t = 0; end
        else if (pg[m_i]) begin
          if (m_i == N - 1) begin m_mode = M_ON; m_safe = 0; m_ready = 1; end
          else begin m_i++; m_k = m_i + 1; m_t = 0; m_mode = M_UP; end
        end
        else if (m_t == TIMEOUT - 1) begin
          m_mode = M_FLT; m_k = 0; m_safe = 1; m_ready = 0; m_fault = 1;
        end
        else m_t++;
      M_ON:
        if (pg != {N{1'b1}}) begin
          m_mode = M_FLT; m_k = 0; m_safe = 1; m_ready = 0; m_fault = 1;
        end else if (!e) begin
          m_mode = M_DOWN; m_t = 0; m_safe = 1; m_ready = 0;
        end
      M_DOWN: begin
        if (m_t == 0) m_k = m_i;
        if (m_t == DELAY - 1) begin
          m_t = 0;
          if (m_i == 0) m_mode = M_IDLE; else m_i--;
        end else m_t++;
      end
      M_FLT: if (!e) begin m_mode = M_IDLE; m_fault = 0; m_i = 0; m_t = 0; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: model sees the same inputs as the DUT, then outputs are compared
  task automatic step();
    logic [N-1:0] pg_next;
    pg_next = exp_seg();
    model_edge(reset, en, pwr_good);
    @(posedge clk);
    #1;
    chk("seg_en", 32'(seg_en), 32'(exp_seg()));
    chk("poc",    32'(poc),    m_safe ? 32'({N{1'b1}}) : 32'd0);
    chk("ready",  32'(ready),  32'(m_ready));
    chk("fault",  32'(fault),  32'(m_fault));
    if (follow) pwr_good = pg_next & pg_mask;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int rise [N];
    reset = 1'b1; en = 1'b0; pwr_good = '0; pg_mask = '1; follow = 1;
    m_mode = M_IDLE; m_k = 0; m_i = 0; m_t = 0; m_safe = 1; m_ready = 0; m_fault = 0;
    steps(2);
    chk("rst_seg_en", 32'(seg_en), 32'd0);
    chk("rst_poc", 32'(poc), 32'hf);
    reset = 1'b0;
    steps(2);

    // power-up: bits rise at edges 0,5,10,15, released after edge 20
    for (int b = 0; b < N; b++) rise[b] = -1;
    en = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      for (int b = 0; b < N; b++) if (seg_en[b] && rise[b] < 0) rise[b] = e;
      if (e == 19) chk("up_ready_early", 32'(ready), 32'd0);
    end
    for (int b = 0; b < N; b++) chk("up_rise_edge", 32'(rise[b]), 32'(5 * b));
    chk("up_ready", 32'(ready), 32'd1);
    chk("up_poc", 32'(poc), 32'd0);

    // orderly power-down in reverse
    en = 1'b0;
    step();  chk("dn_poc", 32'(poc), 32'hf);  chk("dn_seg0", 32'(seg_en), 32'hf);
    step();  chk("dn_seg1", 32'(seg_en), 32'h7);
    steps(4); chk("dn_seg2", 32'(seg_en), 32'h3);
    steps(4); chk("dn_seg3", 32'(seg_en), 32'h1);
    steps(4); chk("dn_seg4", 32'(seg_en), 32'h0);
    steps(6);

    // segment 2 never good: timeout 8 cycles into its check
    pg_mask = 4'b1011; en = 1'b1;
    steps(22); chk("to_fault_early", 32'(fault), 32'd0);
    step();    chk("to_fault", 32'(fault), 32'd1);
    chk("to_seg_en", 32'(seg_en), 32'd0);
    chk("to_poc", 32'(poc), 32'hf);
    en = 1'b0; step(); chk("to_clear", 32'(fault), 32'd0);
    pg_mask = '1; steps(2);

    // one-cycle brown-out on segment 1 while ON
    en = 1'b1; steps(21); chk("bo_on", 32'(ready), 32'd1);
    pg_mask = 4'b1101; step(); pg_mask = '1;
    step();
    chk("bo_ready", 32'(ready), 32'd0);
    chk("bo_poc", 32'(poc), 32'hf);
    chk("bo_fault", 32'(fault), 32'd1);
    en = 1'b0; steps(2);

    // abort while ramping segment 1
    en = 1'b1; steps(8); chk("ab_seg", 32'(seg_en), 32'h3);
    en = 1'b0; step(); chk("ab_entry", 32'(seg_en), 32'h3);
    step();   chk("ab_seg1", 32'(seg_en), 32'h1);
    steps(4); chk("ab_seg0", 32'(seg_en), 32'h0);
    steps(4);

    // reset while checking segment 2
    en = 1'b1; steps(15);
    reset = 1'b1; step(); reset = 1'b0; en = 1'b0;
    chk("rs_seg_en", 32'(seg_en), 32'd0);
    chk("rs_poc", 32'(poc), 32'hf);
    chk("rs_ready", 32'(ready), 32'd0);
    chk("rs_fault", 32'(fault), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) en = ~en;
      reset = ($urandom_range(299) == 0);
      pg_mask = ($urandom_range(59) == 0) ? N'($urandom) : '1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
